flipflop_i_encoder_reg: RTL and testbench
=========================================

# flipflop_i_encoder_reg

Parametrised successor to the per-bit instruction-register encoders. It takes the full one-hot set-line vector from the P2 decode stage and encodes it to a W-bit code, then latches that code into the I flip-flop register on the P2 strobe. It adds a valid/ack handshake toward the sequencer, a sticky multi-hot error flag and a saturating overrun counter. It sits between the decoder set-line fan-out and the instruction flip-flop consumers.

## Interface
- `W`, 8: code width; the set vector is 2**W lines wide.
- `MODE`, 0: 0 = OR-encode (bitwise OR of the codes of all hot lines, matching the legacy gate encoders); 1 = priority (highest hot index wins).
- `RESET_CODE`, 0: value of `i_q` after reset and after `clr`.
- `OVR_W`, 4: width of the overrun counter.

- `clk` input 1: sole clock; everything updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `p2` input 1: load strobe; set lines are sampled only when it is 1.
- `set` input 2**W: set lines; bit k means "load code k". One-hot is expected.
- `ack` input 1: sequencer has consumed `i_q`.
- `clr` input 1: synchronous clear of the register and of `i_valid`.
- `err_clr` input 1: clears `multi_err` and `ovr_cnt`.
- `i_q` output W: registered instruction code.
- `i_valid` output 1: `i_q` holds an unconsumed code.
- `multi_err` output 1: sticky flag; more than one set line was hot at a load.
- `ovr_cnt` output OVR_W: saturating count of loads that overwrote an unconsumed code.

## Operation
- **Load event:** `p2`=1 and `set`≠0 and `clr`=0.
- **Encoding:**
  - MODE 0: `i_q` ← OR over all hot k of k.
  - MODE 1: `i_q` ← the largest hot k.
- **No load:** `p2`=1 with `set`=0 loads nothing; `i_q` and `i_valid` hold.
- **Multi-hot:** popcount(`set`)>1 at a load event sets `multi_err`. The code is still loaded per MODE.
- **`i_valid` state machine** (EMPTY/FULL):
  - EMPTY→FULL on a load.
  - FULL→EMPTY on `ack` without a load.
  - FULL→FULL on a load, with or without `ack`. The new code replaces the old one.
  - `ack` while EMPTY is ignored.
- **Overrun:** a load while FULL and `ack`=0 increments `ovr_cnt`. The counter saturates at 2**OVR_W−1 and never wraps.
- **`clr`:**
  - `i_q` ← RESET_CODE and `i_valid` ← 0.
  - Overrides any load or `ack` in the same cycle.
  - Does not touch `multi_err` or `ovr_cnt`.
- **`err_clr`:**
  - `multi_err` ← 0 and `ovr_cnt` ← 0.
  - If an error or overrun occurs in the same cycle, the set/increment wins: `multi_err`=1, `ovr_cnt`=1.
- **Reset values:** `i_q`=RESET_CODE, `i_valid`=0, `multi_err`=0, `ovr_cnt`=0.

## Timing
- Latency is one cycle: the code sampled at edge n is visible on `i_q`/`i_valid` after edge n.
- `set` is combinational-only into the encoder; no input register.
- `ack` in cycle n clears `i_valid` after edge n.
- Back-to-back loads on consecutive cycles are allowed, one per cycle.
- `rst` asserted mid-operation forces reset values immediately (asynchronously). Deassertion takes effect at the next edge; the first load is accepted on the first edge with `rst`=0.
- No combinational path from any input to any output.

## Structure
- **Shared package `flipflop_i_pkg`:**
  - `I_W` = 8.
  - Mode constants `I_ENC_OR` = 0 and `I_ENC_PRIO` = 1.
  - `i_code_t` typedef.
- **Sub-module `onehot_code_encoder`** (combinational, parametrised by W and MODE): produces `code[W-1:0]`, `any` and `multi`.
- **Top level:** registers, the EMPTY/FULL bit, the overrun counter and the error flag.

## Test plan
- **Reset and single load:** reset, then `p2`=1, `set`=1<<0xCA → next cycle `i_q`=0xCA, `i_valid`=1, `multi_err`=0.
- **Multi-hot:** `set` bits 0x48 and 0x0D hot, `p2`=1.
  - MODE 0 → `i_q`=0x4D, `multi_err`=1.
  - MODE 1 → `i_q`=0x48, `multi_err`=1.
- **Handshake and overrun:**
  - Load 0x38, then load 0x3A without `ack` → `i_q`=0x3A, `ovr_cnt`=1.
  - Next cycle `ack` → `i_valid`=0.
  - Load together with `ack` → `i_valid` stays 1, `ovr_cnt` unchanged.
- **Saturation:** 20 loads with no `ack`, OVR_W=4 → `ovr_cnt`=15 and holds. Then `err_clr` → 0.
- **Priorities:**
  - `clr` and a load in the same cycle → `i_q`=RESET_CODE, `i_valid`=0.
  - `p2`=1 with `set`=0 → no change.
  - `p2`=0 with `set` hot → no change.
- **Async reset:** assert `rst` mid-cycle while `i_valid`=1 and `multi_err`=1 → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/flipflop_i_encoder_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flipflop_i_pkg
//  Description : Shared constants and types for the instruction-register
//                set-line encoder and its register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package flipflop_i_pkg;

    // Default instruction code width (set vector is 2**I_W lines)
    localparam int I_W = 8;

    // Encoder modes
    localparam int I_ENC_OR   = 0;  // OR of the indices of all hot lines
    localparam int I_ENC_PRIO = 1;  // highest hot index wins

    // Instruction code at the default width
    typedef logic [I_W-1:0] i_code_t;

    // Occupancy of the instruction register toward the sequencer
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } i_state_t;

endpackage : flipflop_i_pkg
`default_nettype wire

// File: rtl/flipflop_i_encoder_reg_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_code_encoder
//  Description : Combinational encoder from a 2**W set-line vector to a W-bit
//                code. Also flags "any line hot" and "more than one hot".
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_code_encoder
    import flipflop_i_pkg::*;
#(
    parameter int W    = I_W,
    parameter int MODE = I_ENC_OR
) (
    input  logic [2**W-1:0] set,
    output logic [W-1:0]    code,
    output logic            any,
    output logic            multi
);

    localparam int c_N = 2**W;

    logic w_seen;

    generate
        if (MODE == I_ENC_PRIO) begin : g_prio
            // Ascending scan: the last hot line seen is the highest index
            always_comb begin
                code = '0;
                for (int k = 0; k < c_N; k++) begin
                    if (set[k]) begin
                        code = W'(k);
                    end
                end
            end
        end else begin : g_or
            // Legacy gate-encoder behaviour: OR together every hot index
            always_comb begin
                code = '0;
                for (int k = 0; k < c_N; k++) begin
                    if (set[k]) begin
                        code = code | W'(k);
                    end
                end
            end
        end
    endgenerate

    // Any line hot
    assign any = |set;

    // Multi-hot detection: a second hot line after one has already been seen
    always_comb begin
        w_seen = 1'b0;
        multi  = 1'b0;
        for (int k = 0; k < c_N; k++) begin
            if (set[k]) begin
                if (w_seen) begin
                    multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

endmodule : onehot_code_encoder
`default_nettype wire

// File: rtl/flipflop_i_encoder_reg.sv
`default_nettype none
// ============================================================================
//  Module      : flipflop_i_encoder_reg
//  Description : Encodes the P2 set-line vector and latches the code into the
//                instruction register on the P2 strobe. Provides a valid/ack
//                handshake, a sticky multi-hot error and a saturating overrun
//                counter. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module flipflop_i_encoder_reg
    import flipflop_i_pkg::*;
#(
    parameter int           W          = I_W,
    parameter int           MODE       = I_ENC_OR,
    parameter logic [W-1:0] RESET_CODE = '0,
    parameter int           OVR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p2,
    input  logic [2**W-1:0]  set,
    input  logic             ack,
    input  logic             clr,
    input  logic             err_clr,
    output logic [W-1:0]     i_q,
    output logic             i_valid,
    output logic             multi_err,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam logic [OVR_W-1:0] c_OVR_MAX = '1;

    logic [W-1:0]     w_code;
    logic             w_any;
    logic             w_multi;
    logic             w_load;
    logic             w_overrun;
    logic             w_multi_ev;

    i_state_t         r_state;
    i_state_t         w_state_nxt;
    logic [W-1:0]     r_q;
    logic             r_multi_err;
    logic [OVR_W-1:0] r_ovr_cnt;

    onehot_code_encoder #(
        .W    (W),
        .MODE (MODE)
    ) u_enc (
        .set   (set),
        .code  (w_code),
        .any   (w_any),
        .multi (w_multi)
    );

    // A load needs the strobe, at least one hot line, and no clear pending
    assign w_load     = p2 & w_any & ~clr;
    assign w_overrun  = w_load & (r_state == ST_FULL) & ~ack;
    assign w_multi_ev = w_load & w_multi;

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next state: clear beats load, load beats ack
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_load) begin
            w_state_nxt = ST_FULL;
        end else if (ack) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Instruction code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_CODE;
        end else if (clr) begin
            r_q <= RESET_CODE;
        end else if (w_load) begin
            r_q <= w_code;
        end
    end

    // Sticky multi-hot flag; a new error wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_multi_err <= 1'b0;
        end else if (w_multi_ev) begin
            r_multi_err <= 1'b1;
        end else if (err_clr) begin
            r_multi_err <= 1'b0;
        end
    end

    // Saturating overrun counter; an overrun in the clearing cycle counts as one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr_cnt <= '0;
        end else if (w_overrun) begin
            if (err_clr) begin
                r_ovr_cnt <= OVR_W'(1);
            end else if (r_ovr_cnt != c_OVR_MAX) begin
                r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
            end
        end else if (err_clr) begin
            r_ovr_cnt <= '0;
        end
    end

    assign i_q       = r_q;
    assign i_valid   = (r_state == ST_FULL);
    assign multi_err = r_multi_err;
    assign ovr_cnt   = r_ovr_cnt;

endmodule : flipflop_i_encoder_reg
`default_nettype wire

// File: tb/tb_flipflop_i_encoder_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flipflop_i_encoder_reg
//  Description : Self-checking bench. Two instances (OR mode, priority mode)
//                share stimulus; a reference model pushes expected results
//                into a scoreboard queue that is popped after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flipflop_i_encoder_reg;

    localparam logic [7:0] c_RC0 = 8'h00;
    localparam logic [7:0] c_RC1 = 8'hA5;

    typedef struct packed {
        logic [7:0] q0;
        logic [7:0] q1;
        logic       v;
        logic       m;
        logic [3:0] o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         p2, ack, clr, err_clr;
    logic [255:0] set_v;

    logic [7:0] q0, q1;
    logic       v0, v1, m0, m1;
    logic [3:0] o0, o1;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q0, m_q1;
    logic       m_v, m_m;
    logic [3:0] m_o;

    always #5 clk = ~clk;

    flipflop_i_encoder_reg #(.W(8), .MODE(0), .RESET_CODE(c_RC0), .OVR_W(4)) u_dut_or (
        .clk(clk), .rst(rst), .p2(p2), .set(set_v), .ack(ack), .clr(clr),
        .err_clr(err_clr), .i_q(q0), .i_valid(v0), .multi_err(m0), .ovr_cnt(o0)
    );

    flipflop_i_encoder_reg #(.W(8), .MODE(1), .RESET_CODE(c_RC1), .OVR_W(4)) u_dut_prio (
        .clk(clk), .rst(rst), .p2(p2), .set(set_v), .ack(ack), .clr(clr),
        .err_clr(err_clr), .i_q(q1), .i_valid(v1), .multi_err(m1), .ovr_cnt(o1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_or(input logic [255:0] s);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < 256; k++) if (s[k]) r = r | 8'(k);
        return r;
    endfunction

    function automatic logic [7:0] ref_max(input logic [255:0] s);
        for (int k = 255; k >= 0; k--) if (s[k]) return 8'(k);
        return 8'h00;
    endfunction

    function automatic logic [255:0] hot(input int a);
        logic [255:0] r = '0;
        r[a] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_q0 = c_RC0; m_q1 = c_RC1; m_v = 1'b0; m_m = 1'b0; m_o = 4'd0;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".q_or"},     32'(q0), 32'(e.q0));
        check({tag, ".q_prio"},   32'(q1), 32'(e.q1));
        check({tag, ".valid"},    32'(v0), 32'(e.v));
        check({tag, ".valid_p"},  32'(v1), 32'(e.v));
        check({tag, ".multi"},    32'(m0), 32'(e.m));
        check({tag, ".multi_p"},  32'(m1), 32'(e.m));
        check({tag, ".ovr"},      32'(o0), 32'(e.o));
        check({tag, ".ovr_p"},    32'(o1), 32'(e.o));
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge
    task automatic step(input string tag, input logic p, input logic [255:0] s,
                        input logic a, input logic c, input logic e);
        logic load, ovr, mev;
        exp_t ex;
        p2 = p; set_v = s; ack = a; clr = c; err_clr = e;
        load = p && (s != '0) && !c;
        ovr  = load && m_v && !a;
        mev  = load && ($countones(s) > 1);
        if (c) begin
            m_q0 = c_RC0; m_q1 = c_RC1; m_v = 1'b0;
        end else if (load) begin
            m_q0 = ref_or(s); m_q1 = ref_max(s); m_v = 1'b1;
        end else if (a) begin
            m_v = 1'b0;
        end
        if (ovr) m_o = e ? 4'd1 : ((m_o == 4'd15) ? 4'd15 : m_o + 4'd1);
        else if (e) m_o = 4'd0;
        if (mev) m_m = 1'b1;
        else if (e) m_m = 1'b0;
        sb.push_back('{q0: m_q0, q1: m_q1, v: m_v, m: m_m, o: m_o});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            ex = sb.pop_front();
            check_all(tag, ex);
        end
    endtask

    initial begin
        rst = 1'b1; p2 = 1'b0; ack = 1'b0; clr = 1'b0; err_clr = 1'b0; set_v = '0;
        model_reset();
        #12;
        check_all("reset", '{q0: c_RC0, q1: c_RC1, v: 1'b0, m: 1'b0, o: 4'd0});
        #1 rst = 1'b0;

        // Single load on the first edge after reset release
        step("load_ca", 1'b1, hot(8'hCA), 1'b0, 1'b0, 1'b0);
        // Multi-hot: OR gives 0x4D, priority gives 0x48; overwrites unacked code
        step("multi", 1'b1, hot(8'h48) | hot(8'h0D), 1'b0, 1'b0, 1'b0);
        // Clear errors and consume
        step("errclr_ack", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Handshake and overrun
        step("load_38", 1'b1, hot(8'h38), 1'b0, 1'b0, 1'b0);
        step("load_3a", 1'b1, hot(8'h3A), 1'b0, 1'b0, 1'b0);
        step("ack", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("ack_empty", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("load_38b", 1'b1, hot(8'h38), 1'b0, 1'b0, 1'b0);
        step("load_ack", 1'b1, hot(8'h11), 1'b1, 1'b0, 1'b0);

        // Saturation
        for (int i = 0; i < 20; i++) step("sat", 1'b1, hot(i * 7 + 3), 1'b0, 1'b0, 1'b0);
        step("sat_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("sat_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        // Overrun in the clearing cycle counts as one
        step("clr_race", 1'b1, hot(8'h22), 1'b0, 1'b0, 1'b1);

        // Priorities
        step("clr_load", 1'b1, hot(8'h77), 1'b1, 1'b1, 1'b0);
        step("load_ff", 1'b1, hot(8'hFF), 1'b0, 1'b0, 1'b0);
        step("p2_noset", 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step("set_nop2", 1'b0, hot(8'h01), 1'b0, 1'b0, 1'b0);
        step("load_00", 1'b1, hot(8'h00), 1'b1, 1'b0, 1'b0);

        // Random single- and multi-hot traffic
        for (int i = 0; i < 24; i++) begin
            logic [255:0] s;
            s = hot($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) s = s | hot($urandom_range(0, 255));
            step("rand", $urandom_range(0, 3) != 0, s, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        // Async reset while full with an error flagged
        step("pre_rst", 1'b1, hot(8'h81) | hot(8'h10), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst", '{q0: c_RC0, q1: c_RC1, v: 1'b0, m: 1'b0, o: 4'd0});
        #1 rst = 1'b0;
        step("post_rst", 1'b1, hot(8'h5C), 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound the run in case the clock or a wait stalls
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_flipflop_i_encoder_reg
`default_nettype wire
